// File: rtl/button_conditioner_if.sv
// Button-side bundle of the conditioner: raw asynchronous buttons in, press pulses,
// debounced levels and a debug view of the three channel FSMs out.
interface button_conditioner_if;
  logic       btn_next_raw;
  logic       btn_slower_raw;
  logic       btn_faster_raw;
  logic       next;
  logic       slower;
  logic       faster;
  logic [2:0] held;
  logic [5:0] dbg_state;   // {faster, slower, next} channel FSM states, 2 bits each

  modport master (
    output btn_next_raw, btn_slower_raw, btn_faster_raw,
    input  next, slower, faster, held, dbg_state
  );

  modport slave (
    input  btn_next_raw, btn_slower_raw, btn_faster_raw,
    output next, slower, faster, held, dbg_state
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronizes, debounces and edge-detects the next/slower/faster buttons into press pulses.
// Optional feature macro AUTOREPEAT_EN: held slower/faster buttons auto-repeat.
module button_conditioner #(
  parameter int DB_CYCLES  = 16,
  parameter int CNT_W      = 5,
  parameter int RPT_DELAY  = 64,
  parameter int RPT_PERIOD = 32
) (
  input logic                  clock,
  input logic                  reset_n,
  button_conditioner_if.slave  bus
);
  localparam logic [1:0] ST_RELEASED = 2'd0;
  localparam logic [1:0] ST_PRESSED  = 2'd1;
  localparam logic [1:0] ST_REPEAT   = 2'd2;

  if ((2 ** CNT_W) <= DB_CYCLES) begin : g_cnt_w_check
    $error("CNT_W too narrow for DB_CYCLES");
  end
  if (DB_CYCLES < 2) begin : g_db_check
    $error("DB_CYCLES must be at least 2");
  end
  if (RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_rpt_check
    $error("RPT_DELAY and RPT_PERIOD must be at least 1");
  end

  // Channel index 0 = next, 1 = slower, 2 = faster.
  logic [2:0]       raw;
  logic [2:0]       sync1;
  logic [2:0]       s;
  logic [2:0]       d;
  logic [CNT_W-1:0] db_cnt [3];
  logic [1:0]       state  [3];
  logic [1:0]       state_nx [3];
  logic [2:0]       commit;
  logic [2:0]       fire;
  logic             next_q;
  logic             slower_q;
  logic             faster_q;

`ifdef AUTOREPEAT_EN
  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  logic [RPT_W-1:0] rpt_cnt    [3];
  logic [RPT_W-1:0] rpt_cnt_nx [3];
`endif

  assign raw = {bus.btn_faster_raw, bus.btn_slower_raw, bus.btn_next_raw};

  // A level change is accepted on the edge where the mismatch has lasted DB_CYCLES samples.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      commit[i] = (s[i] != d[i]) && (db_cnt[i] == CNT_W'(DB_CYCLES - 1));
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_nx[i] = state[i];
      fire[i]     = 1'b0;
`ifdef AUTOREPEAT_EN
      rpt_cnt_nx[i] = rpt_cnt[i];
`endif
      case (state[i])
        ST_RELEASED: begin
          if (commit[i] && s[i]) begin
            state_nx[i] = ST_PRESSED;
            fire[i]     = 1'b1;
`ifdef AUTOREPEAT_EN
            rpt_cnt_nx[i] = '0;
`endif
          end
        end
        ST_PRESSED: begin
          if (commit[i] && !s[i]) begin
            state_nx[i] = ST_RELEASED;
          end
`ifdef AUTOREPEAT_EN
          else if (i != 0) begin
            if (rpt_cnt[i] == RPT_W'(RPT_DELAY - 1)) begin
              state_nx[i]   = ST_REPEAT;
              fire[i]       = 1'b1;
              rpt_cnt_nx[i] = '0;
            end else begin
              rpt_cnt_nx[i] = rpt_cnt[i] + 1'b1;
            end
          end
`endif
        end
        ST_REPEAT: begin
`ifdef AUTOREPEAT_EN
          if (commit[i] && !s[i]) begin
            state_nx[i] = ST_RELEASED;
          end else if (rpt_cnt[i] == RPT_W'(RPT_PERIOD - 1)) begin
            fire[i]       = 1'b1;
            rpt_cnt_nx[i] = '0;
          end else begin
            rpt_cnt_nx[i] = rpt_cnt[i] + 1'b1;
          end
`else
          state_nx[i] = ST_RELEASED;
`endif
        end
        default: state_nx[i] = ST_RELEASED;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= '0;
      s        <= '0;
      d        <= '0;
      next_q   <= 1'b0;
      slower_q <= 1'b0;
      faster_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
        state[i]  <= ST_RELEASED;
`ifdef AUTOREPEAT_EN
        rpt_cnt[i] <= '0;
`endif
      end
    end else begin
      sync1 <= raw;
      s     <= sync1;
      for (int i = 0; i < 3; i++) begin
        if (s[i] == d[i]) begin
          db_cnt[i] <= '0;
        end else if (commit[i]) begin
          d[i]      <= s[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
        state[i] <= state_nx[i];
`ifdef AUTOREPEAT_EN
        rpt_cnt[i] <= rpt_cnt_nx[i];
`endif
      end
      // Simultaneous slower/faster pulses cancel each other; nothing is deferred.
      next_q   <= fire[0];
      slower_q <= fire[1] & ~fire[2];
      faster_q <= fire[2] & ~fire[1];
    end
  end

  assign bus.next      = next_q;
  assign bus.slower    = slower_q;
  assign bus.faster    = faster_q;
  assign bus.held      = d;
  assign bus.dbg_state = {state[2], state[1], state[0]};
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=8.
// Define AUTOREPEAT_EN for both bench and RTL to check the auto-repeat build.
module tb_button_conditioner;
  logic clock;
  logic reset_n;
  int   checks_total;
  int   checks_passed;

  button_conditioner_if bus ();

  button_conditioner #(
    .DB_CYCLES (4),
    .CNT_W     (3),
    .RPT_DELAY (20),
    .RPT_PERIOD(8)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // observation state, refreshed at every falling edge by run_cycles
  int         cyc;
  int         n_next, n_slower, n_faster;
  int         first_next, first_slower, first_faster;
  int         dbl_pulse;
  logic [2:0] held_seen;
  logic [2:0] prev_pulse;
  logic [6:0] faster_q[$];
  logic [6:0] exp_q[$];

  task automatic clear_obs();
    cyc = 0;
    n_next = 0; n_slower = 0; n_faster = 0;
    first_next = -1; first_slower = -1; first_faster = -1;
    held_seen = 3'b000;
    faster_q.delete();
  endtask

  task automatic run_cycles(input int n);
    logic [2:0] p;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      cyc++;
      p = {bus.faster, bus.slower, bus.next};
      if (p[0]) begin n_next++;   if (first_next < 0)   first_next = cyc;   end
      if (p[1]) begin n_slower++; if (first_slower < 0) first_slower = cyc; end
      if (p[2]) begin n_faster++; if (first_faster < 0) first_faster = cyc; faster_q.push_back(7'(cyc)); end
      if ((p & prev_pulse) != 3'b000) dbl_pulse++;
      prev_pulse = p;
      held_seen = held_seen | bus.held;
    end
  endtask

  task automatic drive(input logic nx, input logic sl, input logic fa);
    bus.btn_next_raw   = nx;
    bus.btn_slower_raw = sl;
    bus.btn_faster_raw = fa;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1);
    reset_n = 1'b0;
    clear_obs();
    run_cycles(5);
    checks_total++;
    if ({bus.next, bus.slower, bus.faster} !== 3'b000) $display("FAIL reset_pulses got=%b want=000", {bus.next, bus.slower, bus.faster});
    else checks_passed++;
    checks_total++;
    if (bus.held !== 3'b000) $display("FAIL reset_held got=%b want=000", bus.held);
    else checks_passed++;
    checks_total++;
    if (bus.dbg_state !== 6'd0) $display("FAIL reset_state got=%h want=00", bus.dbg_state);
    else checks_passed++;
    checks_total++;
    if (n_next + n_slower + n_faster !== 0) $display("FAIL reset_quiet got=%0d want=0", n_next + n_slower + n_faster);
    else checks_passed++;
    // slower released so the held faster button is not cancelled by the conflict rule
    bus.btn_slower_raw = 1'b0;
    reset_n = 1'b1;
    clear_obs();
    run_cycles(10);
    checks_total++;
    if (n_next !== 1 || first_next !== 6) $display("FAIL reset_next_pulse got=%0d@%0d want=1@6", n_next, first_next);
    else checks_passed++;
    checks_total++;
    if (n_faster !== 1 || first_faster !== 6) $display("FAIL reset_faster_pulse got=%0d@%0d want=1@6", n_faster, first_faster);
    else checks_passed++;
    checks_total++;
    if (n_slower !== 0) $display("FAIL reset_slower_pulse got=%0d want=0", n_slower);
    else checks_passed++;
    checks_total++;
    if (bus.held !== 3'b101) $display("FAIL reset_held_after got=%b want=101", bus.held);
    else checks_passed++;
    drive(1'b0, 1'b0, 1'b0);
    clear_obs();
    run_cycles(10);
    checks_total++;
    if (bus.held !== 3'b000 || n_next + n_faster !== 0) $display("FAIL reset_release got=%b/%0d want=000/0", bus.held, n_next + n_faster);
    else checks_passed++;
  endtask

  task automatic test_clean_press();
    clear_obs();
    bus.btn_next_raw = 1'b1;
    run_cycles(30);
    checks_total++;
    if (n_next !== 1) $display("FAIL press_count got=%0d want=1", n_next);
    else checks_passed++;
    checks_total++;
    if (first_next !== 6) $display("FAIL press_latency got=%0d want=6", first_next);
    else checks_passed++;
    checks_total++;
    if (bus.held[0] !== 1'b1) $display("FAIL press_held got=%b want=1", bus.held[0]);
    else checks_passed++;
    clear_obs();
    bus.btn_next_raw = 1'b0;
    run_cycles(5);
    checks_total++;
    if (bus.held[0] !== 1'b1) $display("FAIL release_early got=%b want=1", bus.held[0]);
    else checks_passed++;
    run_cycles(1);
    checks_total++;
    if (bus.held[0] !== 1'b0) $display("FAIL release_latency got=%b want=0", bus.held[0]);
    else checks_passed++;
    run_cycles(4);
    checks_total++;
    if (n_next !== 0) $display("FAIL release_pulse got=%0d want=0", n_next);
    else checks_passed++;
  endtask

  task automatic test_bounce();
    clear_obs();
    for (int k = 0; k < 40; k++) begin
      bus.btn_slower_raw = ((k % 5) < 3);
      run_cycles(1);
    end
    bus.btn_slower_raw = 1'b0;
    run_cycles(10);
    checks_total++;
    if (n_slower !== 0) $display("FAIL bounce_pulse got=%0d want=0", n_slower);
    else checks_passed++;
    checks_total++;
    if (held_seen[1] !== 1'b0) $display("FAIL bounce_held got=%b want=0", held_seen[1]);
    else checks_passed++;
  endtask

  task automatic test_conflict();
    clear_obs();
    bus.btn_slower_raw = 1'b1;
    bus.btn_faster_raw = 1'b1;
    run_cycles(15);
    checks_total++;
    if (n_slower !== 0 || n_faster !== 0) $display("FAIL conflict_pulses got=%0d/%0d want=0/0", n_slower, n_faster);
    else checks_passed++;
    checks_total++;
    if (bus.held[2:1] !== 2'b11) $display("FAIL conflict_held got=%b want=11", bus.held[2:1]);
    else checks_passed++;
    bus.btn_slower_raw = 1'b0;
    bus.btn_faster_raw = 1'b0;
    run_cycles(10);
    clear_obs();
    bus.btn_faster_raw = 1'b1;
    run_cycles(15);
    checks_total++;
    if (n_faster !== 1 || first_faster !== 6) $display("FAIL faster_alone got=%0d@%0d want=1@6", n_faster, first_faster);
    else checks_passed++;
    checks_total++;
    if (n_slower !== 0) $display("FAIL faster_alone_slower got=%0d want=0", n_slower);
    else checks_passed++;
    bus.btn_faster_raw = 1'b0;
    run_cycles(10);
  endtask

  task automatic test_autorepeat();
    exp_q.delete();
    exp_q.push_back(7'd6);
`ifdef AUTOREPEAT_EN
    exp_q.push_back(7'd26);
    exp_q.push_back(7'd34);
    exp_q.push_back(7'd42);
    exp_q.push_back(7'd50);
    exp_q.push_back(7'd58);
`endif
    clear_obs();
    bus.btn_faster_raw = 1'b1;
    bus.btn_next_raw   = 1'b1;
    run_cycles(60);
    bus.btn_faster_raw = 1'b0;
    bus.btn_next_raw   = 1'b0;
    run_cycles(30);
    checks_total++;
    if (faster_q.size() !== exp_q.size()) $display("FAIL repeat_count got=%0d want=%0d", faster_q.size(), exp_q.size());
    else checks_passed++;
    for (int k = 0; k < exp_q.size(); k++) begin
      checks_total++;
      if (k >= faster_q.size()) $display("FAIL repeat_pulse_%0d got=none want=%0d", k, exp_q[k]);
      else if (faster_q[k] !== exp_q[k]) $display("FAIL repeat_pulse_%0d got=%0d want=%0d", k, faster_q[k], exp_q[k]);
      else checks_passed++;
    end
    checks_total++;
    if (n_next !== 1 || first_next !== 6) $display("FAIL next_no_repeat got=%0d@%0d want=1@6", n_next, first_next);
    else checks_passed++;
  endtask

  task automatic test_mid_press_reset();
    clear_obs();
    bus.btn_next_raw = 1'b1;
    run_cycles(4);
    reset_n = 1'b0;
    run_cycles(3);
    checks_total++;
    if (n_next !== 0 || bus.held !== 3'b000) $display("FAIL midreset_during got=%0d/%b want=0/000", n_next, bus.held);
    else checks_passed++;
    reset_n = 1'b1;
    clear_obs();
    run_cycles(12);
    checks_total++;
    if (n_next !== 1) $display("FAIL midreset_count got=%0d want=1", n_next);
    else checks_passed++;
    checks_total++;
    if (first_next !== 6) $display("FAIL midreset_latency got=%0d want=6", first_next);
    else checks_passed++;
    bus.btn_next_raw = 1'b0;
    run_cycles(10);
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    dbl_pulse     = 0;
    prev_pulse    = 3'b000;
    reset_n       = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    test_reset();
    test_clean_press();
    test_bounce();
    test_conflict();
    test_autorepeat();
    test_mid_press_reset();
    checks_total++;
    if (dbl_pulse !== 0) $display("FAIL double_pulse got=%0d want=0", dbl_pulse);
    else checks_passed++;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
